subtrator_serial: RTL and testbench

Bit-serial N-bit full subtractor (default 4 bits) computing D = A − B − Bin one bit per clock, LSB first, with a start/done handshake. It is the subtraction counterpart of the team's ripple-carry 4-bit adder. It trades the combinational borrow chain for a single reused 1-bit subtractor cell plus shift registers, and feeds the ALU datapath wherever a registered difference with a borrow-out is needed.

---
 rtl/subtrator_pkg.sv | 18 +
 rtl/subtrator_1bit.sv | 18 +
 rtl/subtrator_serial.sv | 122 ++++++++++++
 tb/tb_subtrator_serial.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/subtrator_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default
// operand width and the bit-counter width helper.
package subtrator_pkg;

   localparam int unsigned DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_DONE  = 2'b10
   } state_t;

   // Width of a counter that must reach n-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/subtrator_1bit.sv
// Combinational 1-bit full subtractor: D = A - B - Bin.
// Ports:
//   A, B  : operand bits
//   Bin   : borrow in
//   D     : difference bit
//   Bout  : borrow out
module subtrator_1bit (
   input  logic A,
   input  logic B,
   input  logic Bin,
   output logic D,
   output logic Bout
);

   assign D    = A ^ B ^ Bin;
   assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial N-bit subtractor, D = A - B - Bin, one bit per clock, LSB first.
// A single subtrator_1bit cell is reused every SHIFT cycle.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : request, only honoured in IDLE
//   A, B, Bin    : operands, captured on the accepting edge
//   D, Bout, zero: registered result, updated together at completion
//   busy         : high while bits are being processed
//   done         : one-cycle pulse when the result registers update
module subtrator_serial
   import subtrator_pkg::*;
#(
   parameter int unsigned N = DEF_WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Bin,
   output logic [N-1:0] D,
   output logic         Bout,
   output logic         zero,
   output logic         busy,
   output logic         done
);

   localparam int unsigned CW = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t         state_q;
   logic [N-1:0]   a_q;
   logic [N-1:0]   b_q;
   logic [N-1:0]   res_q;
   logic [N-1:0]   res_d;
   logic           br_q;
   logic [CW-1:0]  cnt_q;
   logic [N-1:0]   d_q;
   logic           bout_q;
   logic           zero_q;
   logic           busy_q;
   logic           done_q;
   logic           bit_d;
   logic           bit_bout;

   // Shared subtractor cell works on the current LSBs and the borrow flop.
   subtrator_1bit u_cell (
      .A    (a_q[0]),
      .B    (b_q[0]),
      .Bin  (br_q),
      .D    (bit_d),
      .Bout (bit_bout)
   );

   // New difference bit enters from the MSB side so bit 0 ends up at LSB.
   assign res_d = {bit_d, res_q[N-1:1]};

   // FSM, datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         d_q     <= '0;
         bout_q  <= 1'b0;
         zero_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= A;
                  b_q     <= B;
                  br_q    <= Bin;
                  res_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               br_q  <= bit_bout;
               res_q <= res_d;
               if (cnt_q == LAST) begin
                  // Last bit: publish the full result with its final borrow.
                  d_q     <= res_d;
                  bout_q  <= bit_bout;
                  zero_q  <= (res_d == '0);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign D    = d_q;
   assign Bout = bout_q;
   assign zero = zero_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_subtrator_serial.sv
// Scoreboard bench for subtrator_serial (N=4): stimulus pushes expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_subtrator_serial;

   typedef struct packed {
      logic [3:0] d;
      logic       bo;
      logic       z;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] A;
   logic [3:0] B;
   logic       Bin;
   logic [3:0] D;
   logic       Bout;
   logic       zero;
   logic       busy;
   logic       done;

   int   checks;
   int   errors;
   int   done_cnt;
   exp_t sb_q[$];

   subtrator_serial #(.N(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .Bin   (Bin),
      .D     (D),
      .Bout  (Bout),
      .zero  (zero),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt++;
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 required=0 D=%0h at %0t", D, $time);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("D", 32'(D), 32'(e.d));
            chk("Bout", 32'(Bout), 32'(e.bo));
            chk("zero", 32'(zero), 32'(e.z));
         end
      end
   end

   // Issue one operation, then measure busy length and done latency.
   task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                        input logic [3:0] ed, input logic eb, input logic ez);
      exp_t e;
      int   busy_n;
      int   lat;
      bit   seen;
      @(negedge clk);
      A = a; B = b; Bin = bin; start = 1'b1;
      e.d = ed; e.bo = eb; e.z = ez;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
      A = 4'($urandom); B = 4'($urandom); Bin = 1'($urandom);
      busy_n = 0; lat = 0; seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         lat++;
         if (busy === 1'b1) busy_n++;
      end
      chk("done_seen", 32'(seen), 32'd1);
      chk("done_latency", 32'(lat), 32'd4);
      chk("busy_cycles", 32'(busy_n), 32'd4);
      @(negedge clk);
      chk("done_pulse_width", 32'(done), 32'd0);
   endtask

   initial begin
      int dc0;
      checks = 0; errors = 0; done_cnt = 0;
      rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_D", 32'(D), 32'd0);
      chk("rst_Bout", 32'(Bout), 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);

      // Directed vectors: A, B, Bin -> D, Bout, zero
      do_op(4'd9, 4'd3, 1'b0, 4'h6, 1'b0, 1'b0);
      do_op(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b0);
      do_op(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);
      do_op(4'd5, 4'd5, 1'b0, 4'h0, 1'b0, 1'b1);
      do_op(4'd15, 4'd0, 1'b1, 4'hE, 1'b0, 1'b0);
      do_op(4'd0, 4'd15, 1'b0, 4'h1, 1'b1, 1'b0);

      // start during SHIFT must be ignored
      dc0 = done_cnt;
      @(negedge clk);
      A = 4'd9; B = 4'd3; Bin = 1'b0; start = 1'b1;
      sb_q.push_back('{d: 4'h6, bo: 1'b0, z: 1'b0});
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      A = 4'd1; B = 4'd1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (8) @(negedge clk);
      chk("busy_ignore_done_count", 32'(done_cnt - dc0), 32'd1);
      chk("busy_ignore_sb_empty", 32'(sb_q.size()), 32'd0);
      do_op(4'd1, 4'd1, 1'b0, 4'h0, 1'b0, 1'b1);

      // Reset mid-operation discards the partial result
      do_op(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);
      dc0 = done_cnt;
      @(negedge clk);
      A = 4'd7; B = 4'd2; Bin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_D", 32'(D), 32'd0);
      chk("midrst_Bout", 32'(Bout), 32'd0);
      chk("midrst_zero", 32'(zero), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      repeat (6) @(negedge clk);
      chk("midrst_no_done", 32'(done_cnt - dc0), 32'd0);
      chk("midrst_idle_busy", 32'(busy), 32'd0);
      do_op(4'd7, 4'd2, 1'b0, 4'h5, 1'b0, 1'b0);

      // start coincident with reset is not captured
      dc0 = done_cnt;
      @(negedge clk);
      A = 4'd3; B = 4'd1; start = 1'b1; rst = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; rst = 1'b0;
      @(negedge clk);
      chk("rst_start_busy", 32'(busy), 32'd0);
      repeat (6) @(negedge clk);
      chk("rst_start_no_done", 32'(done_cnt - dc0), 32'd0);

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
